// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter.
// Gated Gray-code edge counters per RO, synchronised into the clk domain.
module ro_freq_meter #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int GATE_W   = 16,
    parameter int SYNC_CYC = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ro_in,
    input  logic                      start,
    input  logic [GATE_W-1:0]         gate_cycles,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*WIDTH-1:0] count_flat,
    output logic [CHANNELS-1:0]       overflow
);

    localparam int SW = $clog2(SYNC_CYC);
    localparam int TW = (GATE_W > SW) ? GATE_W : SW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    state_t            state;
    state_t            state_nx;
    logic [TW-1:0]     tmr;
    logic [TW-1:0]     tmr_nx;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gate_nx;
    logic              cap;
    logic              clr_q;
    logic              en_q;
    logic              done_q;

    logic [CHANNELS-1:0][WIDTH-1:0] gry_ro;
    logic [CHANNELS-1:0]            ovf_ro;
    logic [CHANNELS-1:0][WIDTH-1:0] gry_s1;
    logic [CHANNELS-1:0][WIDTH-1:0] gry_s2;
    logic [CHANNELS-1:0]            ovf_s1;
    logic [CHANNELS-1:0]            ovf_s2;
    logic [CHANNELS-1:0][WIDTH-1:0] bin_clk;
    logic [CHANNELS-1:0][WIDTH-1:0] count_q;
    logic [CHANNELS-1:0]            ovf_q;

    // RO domain: each channel runs entirely on its own oscillator edge
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]       clr_s;
        logic [1:0]       en_s;
        logic [WIDTH-1:0] gry;
        logic [WIDTH-1:0] bin;
        logic             ovf;

        assign bin = g2b(gry);

        always_ff @(posedge ro_in[i] or posedge rst) begin
            if (rst) begin
                clr_s <= '0;
                en_s  <= '0;
                gry   <= '0;
                ovf   <= 1'b0;
            end else begin
                clr_s <= {clr_s[0], clr_q};
                en_s  <= {en_s[0], en_q};
                if (clr_s[1]) begin
                    gry <= '0;
                    ovf <= 1'b0;
                end else if (en_s[1]) begin
                    if (&bin) begin
                        ovf <= 1'b1;
                    end else begin
                        gry <= b2g(bin + WIDTH'(1));
                    end
                end
            end
        end

        assign gry_ro[i] = gry;
        assign ovf_ro[i] = ovf;
    end

    // Free-running synchronisers; Gray keeps multi-bit sampling coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gry_s1 <= '0;
            gry_s2 <= '0;
            ovf_s1 <= '0;
            ovf_s2 <= '0;
        end else begin
            gry_s1 <= gry_ro;
            gry_s2 <= gry_s1;
            ovf_s1 <= ovf_ro;
            ovf_s2 <= ovf_s1;
        end
    end

    always_comb begin
        bin_clk = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bin_clk[c] = g2b(gry_s2[c]);
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        gate_nx  = gate_q;
        cap      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && gate_cycles != '0) begin
                    gate_nx  = gate_cycles;
                    tmr_nx   = TW'(SYNC_CYC - 1);
                    state_nx = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (tmr == '0) begin
                    tmr_nx   = TW'(gate_q) - TW'(1);
                    state_nx = S_GATE;
                end else begin
                    tmr_nx = tmr - TW'(1);
                end
            end
            S_GATE: begin
                if (tmr == '0) begin
                    tmr_nx   = TW'(SYNC_CYC - 1);
                    state_nx = S_SETTLE;
                end else begin
                    tmr_nx = tmr - TW'(1);
                end
            end
            S_SETTLE: begin
                if (tmr == '0) begin
                    state_nx = S_CAPTURE;
                end else begin
                    tmr_nx = tmr - TW'(1);
                end
            end
            S_CAPTURE: begin
                cap      = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // clr/en are registered so the RO-domain synchronisers see glitch-free levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            tmr     <= '0;
            gate_q  <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= '0;
        end else begin
            state  <= state_nx;
            tmr    <= tmr_nx;
            gate_q <= gate_nx;
            clr_q  <= (state_nx == S_CLEAR);
            en_q   <= (state_nx == S_GATE);
            done_q <= cap;
            if (cap) begin
                count_q <= bin_clk;
                ovf_q   <= ovf_s2;
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign done       = done_q;
    assign count_flat = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed self-checking bench for ro_freq_meter.
// RO channels are behavioural oscillators with adjustable half-periods.
`timescale 1ns/100ps
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ro_in;
    logic        start;
    logic [15:0] gate_cycles;
    logic        busy;
    logic        done;
    logic [63:0] count_flat;
    logic [3:0]  overflow;

    int checks   = 0;
    int failures = 0;

    real  hp0 = 2.0;
    real  hp1 = 2.5;
    real  hp2 = 4.0;
    real  hp3 = 5.0;
    logic [3:0] run = 4'hF;
    logic ro0 = 1'b0;
    logic ro1 = 1'b0;
    logic ro2 = 1'b0;
    logic ro3 = 1'b0;

    always #5 clk = ~clk;
    always begin #(hp0); ro0 = run[0] ? ~ro0 : 1'b0; end
    always begin #(hp1); ro1 = run[1] ? ~ro1 : 1'b0; end
    always begin #(hp2); ro2 = run[2] ? ~ro2 : 1'b0; end
    always begin #(hp3); ro3 = run[3] ? ~ro3 : 1'b0; end
    assign ro_in = {ro3, ro2, ro1, ro0};

    ro_freq_meter dut (
        .clk(clk),
        .rst(rst),
        .ro_in(ro_in),
        .start(start),
        .gate_cycles(gate_cycles),
        .busy(busy),
        .done(done),
        .count_flat(count_flat),
        .overflow(overflow)
    );

    task automatic do_start(input logic [15:0] g);
        @(negedge clk);
        start = 1'b1;
        gate_cycles = g;
        @(negedge clk);
        start = 1'b0;
        gate_cycles = '0;
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        gate_cycles = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (count_flat !== 64'd0 || overflow !== 4'd0) begin
            failures++;
            $display("FAIL reset_data count=%h ovf=%b want 0", count_flat, overflow);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic;
        int n;
        int c;
        int exp [4] = '{2500, 2000, 1250, 1000};
        do_start(16'd1000);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy busy=%b want 1", busy);
        end
        wait_done(1100, n);
        checks++;
        if (n !== 1017) begin
            failures++;
            $display("FAIL basic_latency got=%0d want 1017", n);
        end
        for (int ch = 0; ch < 4; ch++) begin
            c = int'(count_flat[ch*16 +: 16]);
            checks++;
            if (c > exp[ch] + 1 || c + 1 < exp[ch]) begin
                failures++;
                $display("FAIL basic_count%0d got=%0d want %0d+-1", ch, c, exp[ch]);
            end
        end
        checks++;
        if (overflow !== 4'b0000) begin
            failures++;
            $display("FAIL basic_ovf got=%b want 0000", overflow);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulse done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid;
        int nd;
        do_start(16'd1000);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ctl busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (count_flat !== 64'd0 || overflow !== 4'd0) begin
            failures++;
            $display("FAIL midrst_data count=%h ovf=%b want 0", count_flat, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL midrst_nodone got=%0d active cycles want 0", nd);
        end
    endtask

    task automatic test_clear_between;
        int n;
        int c;
        int exp [4] = '{250, 200, 125, 100};
        do_start(16'd1000);
        wait_done(1100, n);
        checks++;
        if (n !== 1017) begin
            failures++;
            $display("FAIL clr_first_latency got=%0d want 1017", n);
        end
        do_start(16'd100);
        wait_done(200, n);
        checks++;
        if (n !== 117) begin
            failures++;
            $display("FAIL clr_latency got=%0d want 117", n);
        end
        for (int ch = 0; ch < 4; ch++) begin
            c = int'(count_flat[ch*16 +: 16]);
            checks++;
            if (c > exp[ch] + 1 || c + 1 < exp[ch]) begin
                failures++;
                $display("FAIL clr_count%0d got=%0d want %0d+-1", ch, c, exp[ch]);
            end
        end
    endtask

    task automatic test_ignored;
        int nb;
        int nd;
        int c;
        logic [63:0] snap;
        int exp [4] = '{2500, 2000, 1250, 1000};
        nb = 0;
        @(negedge clk);
        start = 1'b1;
        gate_cycles = 16'd0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busy === 1'b1 || done === 1'b1) nb++;
            @(negedge clk);
        end
        checks++;
        if (nb !== 0) begin
            failures++;
            $display("FAIL ign_zero got=%0d active cycles want 0", nb);
        end
        do_start(16'd1000);
        repeat (50) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            start = 1'b1;
            gate_cycles = 16'd5;
            @(negedge clk);
            start = 1'b0;
            repeat (10) @(negedge clk);
        end
        nd = 0;
        snap = '0;
        for (int k = 0; k < 1100; k++) begin
            if (done === 1'b1) begin
                nd++;
                snap = count_flat;
            end
            @(negedge clk);
        end
        checks++;
        if (nd !== 1) begin
            failures++;
            $display("FAIL ign_ndone got=%0d want 1", nd);
        end
        for (int ch = 0; ch < 4; ch++) begin
            c = int'(snap[ch*16 +: 16]);
            checks++;
            if (c > exp[ch] + 1 || c + 1 < exp[ch]) begin
                failures++;
                $display("FAIL ign_count%0d got=%0d want %0d+-1", ch, c, exp[ch]);
            end
        end
    endtask

    task automatic test_saturation;
        int n;
        int c;
        hp0 = 2.0;
        hp1 = 5.0;
        hp2 = 5.0;
        hp3 = 5.0;
        repeat (3) @(negedge clk);
        do_start(16'd50000);
        wait_done(51000, n);
        checks++;
        if (n !== 50017) begin
            failures++;
            $display("FAIL sat_latency got=%0d want 50017", n);
        end
        checks++;
        if (count_flat[15:0] !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_count0 got=%h want ffff", count_flat[15:0]);
        end
        checks++;
        if (overflow !== 4'b0001) begin
            failures++;
            $display("FAIL sat_ovf got=%b want 0001", overflow);
        end
        for (int ch = 1; ch < 4; ch++) begin
            c = int'(count_flat[ch*16 +: 16]);
            checks++;
            if (c > 50001 || c < 49999) begin
                failures++;
                $display("FAIL sat_count%0d got=%0d want 50000+-1", ch, c);
            end
        end
        do_start(16'd100);
        wait_done(200, n);
        c = int'(count_flat[15:0]);
        checks++;
        if (c > 251 || c < 249) begin
            failures++;
            $display("FAIL sat_recount0 got=%0d want 250+-1", c);
        end
        checks++;
        if (overflow !== 4'b0000) begin
            failures++;
            $display("FAIL sat_ovf_clear got=%b want 0000", overflow);
        end
    endtask

    task automatic test_stopped;
        int n;
        int c;
        int exp [3] = '{2500, 2000, 1250};
        hp0 = 2.0;
        hp1 = 2.5;
        hp2 = 4.0;
        hp3 = 5.0;
        run = 4'b0111;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_start(16'd1000);
        wait_done(1100, n);
        checks++;
        if (count_flat[63:48] !== 16'd0) begin
            failures++;
            $display("FAIL stop_count3 got=%0d want 0", count_flat[63:48]);
        end
        checks++;
        if (overflow !== 4'b0000) begin
            failures++;
            $display("FAIL stop_ovf got=%b want 0000", overflow);
        end
        for (int ch = 0; ch < 3; ch++) begin
            c = int'(count_flat[ch*16 +: 16]);
            checks++;
            if (c > exp[ch] + 1 || c + 1 < exp[ch]) begin
                failures++;
                $display("FAIL stop_count%0d got=%0d want %0d+-1", ch, c, exp[ch]);
            end
        end
        run = 4'hF;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_clear_between();
        test_ignored();
        test_saturation();
        test_stopped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Multi-channel ring-oscillator frequency meter. Each channel counts rising edges of its ring oscillator in the oscillator's own clock domain, for a gate window of a programmable number of `clk` cycles. The counts are captured into the `clk` domain through Gray-code synchronisers, with per-channel saturation and overflow flags. It sits between the RO array and the sensor readout logic, and is the parametrised, gated, multi-channel successor of the single free-running up counter.

## Interface
- `CHANNELS`, default 4: number of ring-oscillator inputs / counters.
- `WIDTH`, default 16: count width per channel, at least 4.
- `GATE_W`, default 16: width of the gate-length input.
- `SYNC_CYC`, default 8: `clk` cycles spent in each of CLEAR and SETTLE, at least 4.
- `clk`, input, 1: reference clock, all control and outputs.
- `rst`, input, 1: reset, asynchronous, active-high. Resets the `clk` domain and all RO-domain counters and synchronisers.
- `ro_in`, input, `CHANNELS`: ring-oscillator outputs; bit i clocks channel i.
- `start`, input, 1: one-cycle measurement request; sampled only in IDLE.
- `gate_cycles`, input, `GATE_W`: gate length in `clk` cycles; latched on accepted `start`.
- `busy`, output, 1: measurement in progress.
- `done`, output, 1: one-cycle pulse when `count_flat` and `overflow` are updated.
- `count_flat`, output, `CHANNELS*WIDTH`: channel i occupies bits [i*WIDTH +: WIDTH], binary.
- `overflow`, output, `CHANNELS`: bit i set if channel i saturated during the last gate.

## Operation
- **RO domain, per channel i:**
  - `WIDTH`-bit counter, clocked by rising `ro_in[i]`, held in Gray code.
  - `clr` and `en` from the `clk` domain each pass a 2-flop synchroniser clocked by `ro_in[i]`.
  - If synced `clr` is high: counter = 0 and sticky `ovf_i` = 0.
  - Else if synced `en` is high: increment. At binary all-ones the counter holds and `ovf_i` = 1 (saturating, no wrap).
  - Otherwise the counter holds.
- **`clk` domain:** each Gray counter and `ovf_i` pass a 2-flop synchroniser clocked by `clk`, free-running. Gray-to-binary conversion happens after the synchroniser.
- **FSM states:** IDLE, CLEAR, GATE, SETTLE, CAPTURE.
  - IDLE: `start`=1 and `gate_cycles`≠0 → latch `gate_cycles`, go to CLEAR. `start` with `gate_cycles`=0 is ignored.
  - CLEAR: `clr`=1, `en`=0 for `SYNC_CYC` cycles → GATE.
  - GATE: `clr`=0, `en`=1 for exactly the latched G cycles → SETTLE.
  - SETTLE: `en`=0 for `SYNC_CYC` cycles → CAPTURE.
  - CAPTURE: register the converted counts into `count_flat` and the synced flags into `overflow`, pulse `done` → IDLE.
- `busy`=1 in every state except IDLE. `start` while `busy` is ignored.
- Outputs hold their last captured values until the next CAPTURE.
- **Stopped oscillator:** a channel whose `ro_in` does not toggle cannot see `clr`/`en`. It keeps its previous value, which is 0 after `rst`. This is the intended fault signature.
- **Validity constraint:** `SYNC_CYC`·T_clk ≥ 3·T_ro,max + 2·T_clk for every running channel. Under it, captured counts are stable and exact to ±1 edge of gate-boundary uncertainty.
- **`rst` mid-measurement:** FSM → IDLE, outputs → 0, all RO counters → 0. No `done` is produced.

## Timing
- **Reset values:** `busy`=0, `done`=0, `count_flat`=0, `overflow`=0, FSM=IDLE, latched gate=0.
- **Latency:** `start` sampled at edge T gives `busy`=1 after T.
  - CLEAR covers edges T+1..T+`SYNC_CYC`.
  - GATE ends at edge T+`SYNC_CYC`+G.
  - CAPTURE occurs at edge T+2·`SYNC_CYC`+G.
  - At edge T+2·`SYNC_CYC`+G+1: `count_flat`/`overflow` update, `done`=1 for one cycle, `busy`=0.
  - Total latency is 2·`SYNC_CYC`+G+1 cycles.
- A new `start` is accepted in the same cycle `done` is high; FSM is IDLE then.
- Gate length G=1..2^`GATE_W`−1; the counter must not wrap early at the maximum G.
- `ro_in` may be faster than `clk`. No `clk`-domain logic samples `ro_in` directly.

## Test plan
- **Reset/idle:** assert `rst` mid-GATE → `busy`, `done`, `count_flat`, `overflow` all 0 immediately. No `done` follows. Next `start` works normally.
- **Basic measurement:** `clk` 10 ns; RO periods 4/5/8/10 ns; G=1000 → `done` at 1017 cycles after start (`SYNC_CYC`=8). Counts 2500/2000/1250/1000, each ±1. `overflow`=0.
- **Saturation:** RO0 period 4 ns, G=50000 → `count_flat`[15:0]=0xFFFF, `overflow`[0]=1. Other channels (10 ns period) = 50000 ±1 with flag 0.
- **Clear between runs:** run G=1000, then G=100 on the same ROs → second counts 250/200/125/100 ±1. No carry-over; `overflow` cleared.
- **Ignored starts:** `start` with `gate_cycles`=0 → `busy` stays 0, no `done`. `start` pulses during GATE → exactly one `done`, results match the first gate.
- **Stopped channel:** after `rst`, hold `ro_in`[3]=0, G=1000 → channel 3 count = 0, `overflow`[3]=0. Other channels correct.
